// File: rtl/wb_store_buffer_pkg.sv
// Shared definitions for the commit-side store buffer: size encoding, default depth,
// and the size-to-byte-count mapping used by both drain and conflict logic.
package wb_store_buffer_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_WORD  = 2'd1;
    localparam logic [1:0] SZ_DWORD = 2'd2;

    localparam int unsigned SB_DEPTH = 4;

    // Size 3 is illegal but deliberately treated as a full dword.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_WORD: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/sb_overlap_check.sv
// Dword-granular, conservative overlap test between two byte accesses.
// Last-dword arithmetic wraps modulo 2^AW.
module sb_overlap_check
    import wb_store_buffer_pkg::*;
#(
    parameter int unsigned AW = 32
) (
    input  logic [AW-1:0] a_addr,
    input  logic [1:0]    a_size,
    input  logic [AW-1:0] b_addr,
    input  logic [1:0]    b_size,
    output logic          overlap
);

    logic [AW-3:0] a_first, a_last, b_first, b_last;
    logic          a_carry, b_carry;

    always_comb begin
        // An access crosses into the next dword when offset + bytes - 1 exceeds 3.
        a_carry = (3'(a_addr[1:0]) + size_bytes(a_size) - 3'd1) > 3'd3;
        b_carry = (3'(b_addr[1:0]) + size_bytes(b_size) - 3'd1) > 3'd3;
        a_first = a_addr[AW-1:2];
        b_first = b_addr[AW-1:2];
        a_last  = a_first + (AW-2)'(a_carry);
        b_last  = b_first + (AW-2)'(b_carry);
        overlap = (a_first == b_first) || (a_first == b_last) ||
                  (a_last == b_first)  || (a_last == b_last);
    end

endmodule

// File: rtl/wb_store_buffer.sv
// In-order store buffer between writeback and the dcache, with load-conflict detection
// against every queued entry and the store being pushed this cycle.
module wb_store_buffer
    import wb_store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          wb_st_v,
    input  logic [AW-1:0] wb_st_addr,
    input  logic [DW-1:0] wb_st_data,
    input  logic [1:0]    wb_st_size,
    output logic          sb_full,
    output logic          sb_empty,
    output logic          sb_overflow,
    output logic          sb_dc_req_v,
    output logic [AW-1:0] sb_dc_addr,
    output logic [DW-1:0] sb_dc_data,
    output logic [1:0]    sb_dc_size,
    input  logic          dc_sb_ack,
    input  logic          mem_ld_v,
    input  logic [AW-1:0] mem_ld_addr,
    input  logic [1:0]    mem_ld_size,
    output logic          sb_ld_conflict
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [AW-1:0]    ent_addr [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    logic [1:0]       ent_size [DEPTH];
    logic [DEPTH-1:0] ent_hit;
    logic             push, pop, in_hit;

    assign sb_full     = (count == CW'(DEPTH));
    assign sb_empty    = (count == '0);
    assign sb_dc_req_v = !sb_empty;
    assign sb_overflow = overflow;
    assign push        = wb_st_v && !sb_full;
    assign pop         = sb_dc_req_v && dc_sb_ack;
    assign sb_dc_addr  = ent_addr[head];
    assign sb_dc_data  = ent_data[head];
    assign sb_dc_size  = ent_size[head];

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
            if (wb_st_v && sb_full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && tail == PW'(i)) begin
                ent_addr[i] <= wb_st_addr;
                ent_data[i] <= wb_st_data;
                ent_size[i] <= wb_st_size;
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] offset;
        logic          valid, raw_hit;

        // Entry is live when its distance from head is below the occupancy.
        assign offset     = PW'(i) - head;
        assign valid      = {1'b0, offset} < count;
        assign ent_hit[i] = valid && raw_hit;

        sb_overlap_check #(.AW(AW)) u_ovl (
            .a_addr  (mem_ld_addr),
            .a_size  (mem_ld_size),
            .b_addr  (ent_addr[i]),
            .b_size  (ent_size[i]),
            .overlap (raw_hit)
        );
    end

    sb_overlap_check #(.AW(AW)) u_ovl_in (
        .a_addr  (mem_ld_addr),
        .a_size  (mem_ld_size),
        .b_addr  (wb_st_addr),
        .b_size  (wb_st_size),
        .overlap (in_hit)
    );

    assign sb_ld_conflict = mem_ld_v && ((|ent_hit) || (push && in_hit));

endmodule

// File: tb/tb_wb_store_buffer.sv
// Directed bench for wb_store_buffer: stimulus queues expected drains, a monitor checks
// every dcache handshake against that queue; flags and conflicts checked inline.
module tb_wb_store_buffer;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        wb_st_v;
    logic [31:0] wb_st_addr, wb_st_data;
    logic [1:0]  wb_st_size;
    logic        sb_full, sb_empty, sb_overflow, sb_dc_req_v;
    logic [31:0] sb_dc_addr, sb_dc_data;
    logic [1:0]  sb_dc_size;
    logic        dc_sb_ack;
    logic        mem_ld_v;
    logic [31:0] mem_ld_addr;
    logic [1:0]  mem_ld_size;
    logic        sb_ld_conflict;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } ent_t;

    ent_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    wb_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .CLK            (CLK),
        .CLR            (CLR),
        .wb_st_v        (wb_st_v),
        .wb_st_addr     (wb_st_addr),
        .wb_st_data     (wb_st_data),
        .wb_st_size     (wb_st_size),
        .sb_full        (sb_full),
        .sb_empty       (sb_empty),
        .sb_overflow    (sb_overflow),
        .sb_dc_req_v    (sb_dc_req_v),
        .sb_dc_addr     (sb_dc_addr),
        .sb_dc_data     (sb_dc_data),
        .sb_dc_size     (sb_dc_size),
        .dc_sb_ack      (dc_sb_ack),
        .mem_ld_v       (mem_ld_v),
        .mem_ld_addr    (mem_ld_addr),
        .mem_ld_size    (mem_ld_size),
        .sb_ld_conflict (sb_ld_conflict)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every accepted drain must match the oldest expected store.
    always @(negedge CLK) begin
        if (CLR === 1'b1 && sb_dc_req_v === 1'b1 && dc_sb_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL drain_unexpected: got addr %0h, expected no drain", sb_dc_addr);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                check("drain_addr", 64'(sb_dc_addr), 64'(e.addr));
                check("drain_data", 64'(sb_dc_data), 64'(e.data));
                check("drain_size", 64'(sb_dc_size), 64'(e.size));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic drive_push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                              input bit accepted);
        wb_st_v    = 1'b1;
        wb_st_addr = a;
        wb_st_data = d;
        wb_st_size = s;
        if (accepted) exp_q.push_back('{addr: a, data: d, size: s});
    endtask

    task automatic drive_load(input logic v, input logic [31:0] a, input logic [1:0] s);
        mem_ld_v    = v;
        mem_ld_addr = a;
        mem_ld_size = s;
    endtask

    task automatic ack_cycles(input int n);
        dc_sb_ack = 1'b1;
        repeat (n) tick();
        dc_sb_ack = 1'b0;
    endtask

    initial begin
        CLR = 1'b0; wb_st_v = 1'b0; wb_st_addr = '0; wb_st_data = '0; wb_st_size = '0;
        dc_sb_ack = 1'b0; mem_ld_v = 1'b0; mem_ld_addr = '0; mem_ld_size = '0;
        tick();
        tick();
        CLR = 1'b1;

        // Reset state
        sample();
        check("rst_empty", 64'(sb_empty), 64'd1);
        check("rst_full", 64'(sb_full), 64'd0);
        check("rst_req_v", 64'(sb_dc_req_v), 64'd0);
        check("rst_overflow", 64'(sb_overflow), 64'd0);
        drive_load(1'b1, 32'h0, 2'd0);
        #1;
        check("rst_conflict", 64'(sb_ld_conflict), 64'd0);

        // 1: single store held stable without ack, then drained
        tick();
        drive_push(32'h1000, 32'hDEADBEEF, 2'd2, 1'b1);
        drive_load(1'b1, 32'h1002, 2'd0);
        sample();
        check("t1_incoming_conflict", 64'(sb_ld_conflict), 64'd1);
        tick();
        wb_st_v = 1'b0;
        drive_load(1'b0, 32'h0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            sample();
            check("t1_hold_req_v", 64'(sb_dc_req_v), 64'd1);
            check("t1_hold_addr", 64'(sb_dc_addr), 64'h1000);
            check("t1_hold_data", 64'(sb_dc_data), 64'hDEADBEEF);
            tick();
        end
        ack_cycles(1);
        sample();
        check("t1_empty_after_ack", 64'(sb_empty), 64'd1);

        // 2: fill, overflow, drain in order
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_push(32'(16 * (i + 1)), 32'(100 + i), 2'd0, 1'b1);
            tick();
        end
        wb_st_v = 1'b0;
        sample();
        check("t2_full", 64'(sb_full), 64'd1);
        tick();
        drive_push(32'h50, 32'h55, 2'd0, 1'b0);
        sample();
        check("t2_overflow_before", 64'(sb_overflow), 64'd0);
        tick();
        wb_st_v = 1'b0;
        sample();
        check("t2_overflow_set", 64'(sb_overflow), 64'd1);
        check("t2_still_full", 64'(sb_full), 64'd1);
        tick();
        ack_cycles(4);
        sample();
        check("t2_empty", 64'(sb_empty), 64'd1);
        check("t2_overflow_sticky", 64'(sb_overflow), 64'd1);

        // 3: push+ack while full drops the push; push+ack at count 2 keeps count
        tick();
        CLR = 1'b0;
        exp_q.delete();
        tick();
        CLR = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_push(32'(32'h100 + 4 * i), 32'(200 + i), 2'd2, 1'b1);
            tick();
        end
        drive_push(32'h99, 32'h99, 2'd2, 1'b0);
        dc_sb_ack = 1'b1;
        tick();
        wb_st_v   = 1'b0;
        dc_sb_ack = 1'b0;
        sample();
        check("t3_not_full_count3", 64'(sb_full), 64'd0);
        check("t3_overflow", 64'(sb_overflow), 64'd1);
        tick();
        ack_cycles(1);
        sample();
        check("t3_count2_not_empty", 64'(sb_empty), 64'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive_push(32'(32'h200 + 4 * i), 32'(300 + i), 2'(i % 3), 1'b1);
            dc_sb_ack = 1'b1;
            tick();
        end
        wb_st_v   = 1'b0;
        dc_sb_ack = 1'b0;
        sample();
        check("t3_stream_not_full", 64'(sb_full), 64'd0);
        check("t3_stream_not_empty", 64'(sb_empty), 64'd0);
        tick();
        ack_cycles(1);
        sample();
        check("t3_count1_not_empty", 64'(sb_empty), 64'd0);
        tick();
        ack_cycles(1);
        sample();
        check("t3_drained_empty", 64'(sb_empty), 64'd1);

        // 4: unaligned word store crossing into the next dword
        tick();
        drive_push(32'h103, 32'hA, 2'd1, 1'b1);
        tick();
        wb_st_v = 1'b0;
        drive_load(1'b1, 32'h104, 2'd0);
        sample();
        check("t4_cross_dword_conflict", 64'(sb_ld_conflict), 64'd1);
        drive_load(1'b1, 32'h108, 2'd2);
        #1;
        check("t4_no_conflict", 64'(sb_ld_conflict), 64'd0);
        drive_load(1'b0, 32'h104, 2'd0);
        #1;
        check("t4_ld_v_low", 64'(sb_ld_conflict), 64'd0);
        tick();
        ack_cycles(1);
        drive_load(1'b1, 32'h104, 2'd0);
        sample();
        check("t4_popped_no_conflict", 64'(sb_ld_conflict), 64'd0);
        tick();
        drive_push(32'h100, 32'hB, 2'd0, 1'b1);
        drive_load(1'b1, 32'h100, 2'd0);
        sample();
        check("t4_incoming_empty_conflict", 64'(sb_ld_conflict), 64'd1);
        tick();
        wb_st_v = 1'b0;
        drive_load(1'b0, 32'h0, 2'd0);
        ack_cycles(1);

        // 5: address wrap in last-dword arithmetic
        drive_push(32'hFFFFFFFF, 32'hC, 2'd1, 1'b1);
        tick();
        wb_st_v = 1'b0;
        drive_load(1'b1, 32'h0, 2'd0);
        sample();
        check("t5_wrap_conflict", 64'(sb_ld_conflict), 64'd1);
        drive_load(1'b1, 32'h8, 2'd0);
        #1;
        check("t5_wrap_no_conflict", 64'(sb_ld_conflict), 64'd0);
        tick();
        drive_load(1'b0, 32'h0, 2'd0);
        ack_cycles(1);

        // 6: reset mid-operation discards queue and ignores same-cycle ack
        for (int i = 0; i < 3; i++) begin
            drive_push(32'(32'h300 + 4 * i), 32'(400 + i), 2'd2, 1'b1);
            tick();
        end
        wb_st_v = 1'b0;
        sample();
        check("t6_req_v_before", 64'(sb_dc_req_v), 64'd1);
        check("t6_overflow_before", 64'(sb_overflow), 64'd1);
        tick();
        CLR       = 1'b0;
        dc_sb_ack = 1'b1;
        exp_q.delete();
        tick();
        CLR       = 1'b1;
        dc_sb_ack = 1'b0;
        sample();
        check("t6_empty", 64'(sb_empty), 64'd1);
        check("t6_req_v", 64'(sb_dc_req_v), 64'd0);
        check("t6_overflow", 64'(sb_overflow), 64'd0);
        check("t6_full", 64'(sb_full), 64'd0);
        tick();
        drive_push(32'h777, 32'hD, 2'd2, 1'b1);
        tick();
        wb_st_v = 1'b0;
        sample();
        check("t6_new_head", 64'(sb_dc_addr), 64'h777);
        tick();
        ack_cycles(1);
        sample();
        check("t6_final_empty", 64'(sb_empty), 64'd1);
        check("leftover_expected", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_store_buffer.md
# wb_store_buffer

Commit-side store buffer sitting between the writeback stage and the data cache. Writeback issues validated, architecturally committed stores (its validated dcache-write strobe plus address, data and size). This block queues them in order and drains them to the dcache over a request/acknowledge handshake. It also tells the memory stage to stall any load that overlaps a pending store, and tells halt logic when all stores are drained.

## Interface
Parameters:
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  reset. Synchronous, active-low: sampled on the CLK rising edge, takes effect when 0.
- wb_st_v  in  1  validated store from writeback (already qualified by the writeback valid bit).
- wb_st_addr  in  AW  byte address of the store.
- wb_st_data  in  DW  store data, right-aligned.
- wb_st_size  in  2  store size: 0 = byte, 1 = word, 2 = dword; 3 is illegal.
- sb_full  out  1  count == DEPTH; writeback stalls on this.
- sb_empty  out  1  count == 0; halt logic waits on this.
- sb_overflow  out  1  sticky error flag.
- sb_dc_req_v  out  1  a drain request is presented to the dcache.
- sb_dc_addr  out  AW  address of the head entry.
- sb_dc_data  out  DW  data of the head entry.
- sb_dc_size  out  2  size of the head entry.
- dc_sb_ack  in  1  dcache accepts the head entry this cycle.
- mem_ld_v  in  1  the memory stage has a load this cycle.
- mem_ld_addr  in  AW  load byte address.
- mem_ld_size  in  2  load size, same encoding as wb_st_size.
- sb_ld_conflict  out  1  the load overlaps a pending or incoming store; the memory stage must stall.

## Operation
- The queue is a circular buffer with a head pointer, a tail pointer and a count register that is log2(DEPTH)+1 bits wide.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- **Push:** when wb_st_v=1 and count<DEPTH, the entry is written at tail and tail increments.
- **Push while full:** when wb_st_v=1 and count==DEPTH, the store is dropped, no state changes, and sb_overflow is set. sb_overflow stays set until reset. A same-cycle ack does not rescue the push.
- **Pop:** when sb_dc_req_v=1 and dc_sb_ack=1, head increments.
- **Push and pop in the same cycle:** count is unchanged and both pointers advance.
- **Ack while empty:** dc_sb_ack with sb_dc_req_v=0 is ignored.
- **Drain outputs:** sb_dc_req_v = (count != 0). The addr, data and size outputs come straight from the head entry.
  - While req_v is high and ack is low, addr, data and size hold stable.
  - Entries drain strictly in push order.
- **Conflict check:**
  - For the load and for each candidate store, first dword = addr[AW-1:2] and last dword = (addr + bytes - 1)[AW-1:2], where bytes = 1, 2 or 4 from size.
  - Two accesses overlap when either of the load's dwords equals either of the store's dwords. This is a dword-granular, conservative check.
  - Candidates are every valid entry plus the incoming push (wb_st_v=1 and not full).
  - sb_ld_conflict = mem_ld_v AND (any candidate overlaps). It is purely combinational.
- **Illegal size 3:** treated as 4 bytes in both the conflict check and the drain. It is not flagged.
- **Address wrap:** the last-dword arithmetic is modulo 2^AW, so a store at 0xFFFFFFFF with size 2 wraps and its last dword is 0.

## Timing
- **Reset values:** count=0, head=0, tail=0, sb_overflow=0, sb_full=0, sb_empty=1, sb_dc_req_v=0. sb_ld_conflict follows the reset-empty state (it is asserted only by an incoming push). Entry storage is not reset.
- **Reset mid-operation:** all queued stores are discarded at the edge where CLR=0. Any dcache ack arriving in that cycle is ignored. The dcache must abandon an outstanding request when it sees sb_dc_req_v drop.
- **Push-to-drain latency:** a store pushed at edge N is presented with sb_dc_req_v=1 in cycle N+1, earliest ack at edge N+1. Minimum store-to-dcache latency is 1 cycle.
- **Throughput:** one push and one pop per cycle, sustained.
- **Full and empty:** sb_full and sb_empty are decoded from the registered count only, so neither depends on dc_sb_ack in the same cycle.
- **Conflict path:** sb_ld_conflict is combinational from mem_ld_* and wb_st_*. A popped entry stops conflicting in the cycle after its ack.

## Structure
- Shared package holds:
  - the size encoding constants SZ_BYTE=0, SZ_WORD=1, SZ_DWORD=2;
  - the default SB_DEPTH=4;
  - a size-to-byte-count function.
- One sub-module: sb_overlap_check. Inputs are two address/size pairs, output is the overlap bit. It is instantiated once per entry plus once for the incoming push.
- Entry storage is one register set per entry (addr, data, size), written under a tail-decode enable.

## Test plan
1. Push 0x1000/0xDEADBEEF/dword with ack held 0 → req_v=1 next cycle, addr=0x1000, data=0xDEADBEEF, and all three hold for 5 cycles; ack once → sb_empty=1 the next cycle.
2. Push 4 stores (addr 0x10, 0x20, 0x30, 0x40) back-to-back with no ack → sb_full=1. A 5th push → dropped, sb_overflow=1 and stays 1. Ack 4 times → drain order 0x10, 0x20, 0x30, 0x40.
3. Full queue with push and ack in the same cycle → push dropped, overflow set, count 3. With count=2, simultaneous push and ack → count stays 2; ten cycles of continuous push and ack → pointers wrap and order is preserved.
4. Store at 0x103/word is queued:
   - load 0x104/byte → conflict=1, because the store's last dword is 0x104>>2;
   - load 0x108/dword → conflict=0;
   - load 0x100/byte in the same cycle as an incoming push to 0x100 into an empty buffer → conflict=1.
5. Wrap case: store at 0xFFFFFFFF/word, load at 0x0/byte → conflict=1.
6. Three entries queued with req_v=1, then CLR=0 for one cycle with ack=1 → next cycle count=0, req_v=0, overflow=0, sb_empty=1. A new push after reset drains first.
